tanh_lut_arbiter: RTL and testbench

Round-robin arbiter that shares one negedge-registered tanh lookup table (8-bit signed, Q7) among NREQ neuron datapaths in the NAR-Net hidden layer. Each requester presents a pre-activation byte with a valid/ready handshake. The block drives the table address, captures the table output and returns the result to the owning requester. Result delivery is also valid/ready, so a stalled neuron holds the shared table.

---
 rtl/nar_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/tanh_lut_arbiter.sv | 112 +++++++++++
 tb/tb_tanh_lut_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nar_pkg.sv
// Shared constants and types for the NAR-Net hidden-layer activation path.
package nar_pkg;

  localparam int NAR_N = 8;
  localparam int NAR_Q = 7;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } arb_state_e;

  localparam arb_state_e       RST_STATE = IDLE;
  localparam int               RST_IDX   = 0;
  localparam logic [NAR_N-1:0] RST_BYTE  = '0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// searching upward and wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any && valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tanh_lut_arbiter.sv
// Shares one falling-edge tanh table among NREQ neurons: round-robin accept,
// one-cycle lookup, then hold the result until its owner takes it.
module tanh_lut_arbiter
  import nar_pkg::*;
#(
  parameter int N    = NAR_N,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [N-1:0]      lut_addr,
  input  logic [N-1:0]      lut_data
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [N-1:0]    lut_addr_q, lut_addr_d;
  logic [N-1:0]    rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            rsp_hs;
  logic            accept;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    lut_addr_d  = lut_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    accept      = 1'b0;
    // Only the owner's ready completes a result; others are ignored.
    rsp_hs      = (state_q == RESP) && rsp_ready[gid_q];

    case (state_q)
      IDLE: begin
        accept = pick_any;
      end
      LOOKUP: begin
        rsp_data_d         = lut_data;
        rsp_valid_d        = '0;
        rsp_valid_d[gid_q] = 1'b1;
        state_d            = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
          accept      = pick_any;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      req_ready  = pick_grant & {NREQ{rst_n}};
      lut_addr_d = req_data[pick_idx*N +: N];
      gid_d      = pick_idx;
      ptr_d      = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
      state_d    = LOOKUP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      ptr_q       <= IW'(RST_IDX);
      gid_q       <= IW'(RST_IDX);
      lut_addr_q  <= N'(RST_BYTE);
      rsp_data_q  <= N'(RST_BYTE);
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      lut_addr_q  <= lut_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign lut_addr  = lut_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_tanh_lut_arbiter.sv
// Directed bench for tanh_lut_arbiter with a falling-edge tanh table model
// and a scoreboard of accepted requests versus delivered results.
module tb_tanh_lut_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_ready;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         gid;
    logic [7:0] data;
    int         acc;
  } sb_t;

  sb_t        sb[$];
  sb_t        mon_e;
  int         mon_gi;
  logic [3:0] prev_rv = 4'h0;

  int         order[5] = '{0, 1, 2, 3, 0};
  logic [7:0] res[4]   = '{8'h1F, 8'h61, 8'h9F, 8'h00};
  int         grants;
  int         rsps;
  int         last_acc;

  tanh_lut_arbiter #(
    .N    (8),
    .NREQ (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data)
  );

  always #5 clk = ~clk;

  // Q7 tanh, truncated toward zero.
  function automatic logic [7:0] tanh_q7(input logic [7:0] a);
    int  ai;
    int  r;
    real x;
    real y;
    ai = int'($signed(a));
    x  = real'(ai) / 128.0;
    y  = $tanh(x) * 128.0;
    r  = $rtoi(y);
    return r[7:0];
  endfunction

  always @(negedge clk) lut_data <= tanh_q7(lut_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, pop on result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_rv <= 4'h0;
    end else begin
      if (rsp_valid != 4'h0 && prev_rv == 4'h0) begin
        chk("sb_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("latency", cyc - sb[0].acc, 32'd1);
      end
      if ((rsp_valid & rsp_ready) != 4'h0) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_owner", rsp_valid, 32'(1) << mon_e.gid);
          chk("sb_data", rsp_data, mon_e.data);
        end
      end
      if ((req_valid & req_ready) != 4'h0) begin
        mon_gi = 0;
        for (int k = 0; k < 4; k++) if (req_ready[k]) mon_gi = k;
        mon_e.gid  = mon_gi;
        mon_e.data = tanh_q7(req_data[mon_gi*8 +: 8]);
        mon_e.acc  = cyc + 1;
        sb.push_back(mon_e);
      end
      prev_rv <= rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = 4'h0;
    req_data  = 32'h0;
    rsp_ready = 4'h0;
    #1 rst_n  = 1'b0;

    // Reset state, with requests present.
    #6;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_lut_addr", lut_addr, 32'h0);
    req_valid = 4'h0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single request from requester 1.
    req_data[15:8] = 8'h10;
    req_valid      = 4'b0010;
    rsp_ready      = 4'hF;
    #1;
    chk("single_req_ready", req_ready, 32'b0010);
    tick();
    req_valid = 4'h0;
    #1;
    chk("single_lut_addr", lut_addr, 32'h10);
    chk("single_lookup_rv", rsp_valid, 32'h0);
    tick();
    chk("single_rsp_valid", rsp_valid, 32'b0010);
    chk("single_rsp_data", rsp_data, 32'h0F);
    tick();
    chk("single_rsp_clear", rsp_valid, 32'h0);

    // Back-pressure: owner not ready while another requester waits.
    rsp_ready      = 4'h0;
    req_data[15:8] = 8'h40;
    req_valid      = 4'b0010;
    #1;
    chk("bp_accept", req_ready, 32'b0010);
    tick();
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h55;
    #1;
    chk("lookup_req_ready", req_ready, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 32'b0010);
      chk("bp_rsp_data", rsp_data, 32'h3B);
      chk("bp_req_ready", req_ready, 32'h0);
      chk("bp_lut_addr", lut_addr, 32'h40);
      tick();
    end

    // Reset asserted mid-cycle while holding a result.
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_rsp_valid", rsp_valid, 32'h0);
    chk("rst2_rsp_data", rsp_data, 32'h0);
    chk("rst2_lut_addr", lut_addr, 32'h0);
    chk("rst2_req_ready", req_ready, 32'h0);
    req_valid = 4'h0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Saturated fairness; first grant to 0 shows ptr restarted.
    req_data  = {8'hFF, 8'h80, 8'h7F, 8'h20};
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    #1;
    grants   = 0;
    rsps     = 0;
    last_acc = 0;
    for (int c = 0; c < 40 && (grants < 5 || rsps < 5); c++) begin
      if (rsp_valid != 4'h0 && rsps < 5) begin
        chk("fair_rsp_owner", rsp_valid, 32'(1) << order[rsps]);
        chk("fair_rsp_data", rsp_data, res[order[rsps]]);
        rsps++;
      end
      if (req_ready != 4'h0 && grants < 5) begin
        chk("fair_grant", req_ready, 32'(1) << order[grants]);
        if (grants > 0) chk("fair_spacing", c - last_acc, 32'd2);
        last_acc = c;
        grants++;
      end
      tick();
      if (grants == 5) req_valid = 4'h0;
      #1;
    end
    chk("fair_complete", grants * 10 + rsps, 32'd55);

    // Wrong-owner ready, then chained service to requester 2.
    rsp_ready       = 4'h0;
    req_data[31:24] = 8'hC0;
    req_valid       = 4'b1000;
    #1;
    chk("w_accept", req_ready, 32'b1000);
    tick();
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h40;
    #1;
    tick();
    rsp_ready = 4'b0001;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("w_rsp_valid", rsp_valid, 32'b1000);
      chk("w_rsp_data", rsp_data, 32'hC5);
      chk("w_req_ready", req_ready, 32'h0);
      tick();
    end
    chk("w_still_resp", rsp_valid, 32'b1000);
    rsp_ready = 4'b1000;
    #1;
    chk("chain_req_ready", req_ready, 32'b0100);
    tick();
    req_valid = 4'h0;
    #1;
    chk("chain_lookup_rv", rsp_valid, 32'h0);
    chk("chain_lut_addr", lut_addr, 32'h40);
    tick();
    chk("chain_rsp_valid", rsp_valid, 32'b0100);
    chk("chain_rsp_data", rsp_data, 32'h3B);
    rsp_ready = 4'b0100;
    tick();
    chk("chain_rsp_clear", rsp_valid, 32'h0);
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
